// File: rtl/pb_operand_accumulator_if.sv
// Operand switch/button bus and result outputs of the operand accumulator.
// The board side drives the master modport, the accumulator takes the slave.
interface pb_operand_accumulator_if #(
    parameter int WIDTH        = 4,
    parameter int NUM_OPERANDS = 5,
    parameter int SUM_WIDTH    = 8
);
    logic [WIDTH-1:0]        y;
    logic [NUM_OPERANDS-1:0] pb;
    logic                    rot;
    logic [SUM_WIDTH-1:0]    sum;
    logic                    busy;
    logic                    done;

    modport master (
        output y, pb, rot,
        input  sum, busy, done
    );

    modport slave (
        input  y, pb, rot,
        output sum, busy, done
    );
endinterface

// File: rtl/pb_operand_accumulator.sv
// Push-button operand bank with a sequential multi-cycle summation.
// Slots load on pb rising edges; a rot rising edge sums all slots.
module pb_operand_accumulator #(
    parameter int WIDTH        = 4,
    parameter int NUM_OPERANDS = 5,
    parameter int SUM_WIDTH    = 8,
    parameter int SIGNED       = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pb_operand_accumulator_if.slave  bus
);

    localparam int IDXW = $clog2(NUM_OPERANDS);
    localparam logic [IDXW-1:0] LAST = IDXW'(NUM_OPERANDS - 1);

    if (NUM_OPERANDS < 2) begin : g_chk_n
        $error("pb_operand_accumulator: NUM_OPERANDS must be >= 2");
    end
    if (SUM_WIDTH < WIDTH + $clog2(NUM_OPERANDS)) begin : g_chk_w
        $error("pb_operand_accumulator: SUM_WIDTH too small");
    end

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t                  state;
    logic [NUM_OPERANDS-1:0] pb_q;
    logic [NUM_OPERANDS-1:0] pb_rise;
    logic                    rot_q;
    logic                    rot_rise;
    logic [WIDTH-1:0]        slot [NUM_OPERANDS];
    logic [IDXW-1:0]         idx;
    logic [IDXW-1:0]         ld_idx;
    logic                    ld_hit;
    logic [SUM_WIDTH-1:0]    acc;
    logic [SUM_WIDTH-1:0]    addend;
    logic [SUM_WIDTH-1:0]    sum_r;
    logic                    busy_r;
    logic                    done_r;

    function automatic logic [SUM_WIDTH-1:0] ext(
        input logic [WIDTH-1:0] v
    );
        if (SIGNED != 0)
            ext = {{(SUM_WIDTH-WIDTH){v[WIDTH-1]}}, v};
        else
            ext = {{(SUM_WIDTH-WIDTH){1'b0}}, v};
    endfunction

    assign pb_rise  = bus.pb & ~pb_q;
    assign rot_rise = bus.rot & ~rot_q;
    assign addend   = ext(slot[idx]);

    // Scan high to low so the lowest pressed index wins.
    always_comb begin
        ld_hit = 1'b0;
        ld_idx = '0;
        for (int i = NUM_OPERANDS - 1; i >= 0; i--) begin
            if (pb_rise[i]) begin
                ld_hit = 1'b1;
                ld_idx = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pb_q   <= '0;
            rot_q  <= 1'b0;
            idx    <= '0;
            acc    <= '0;
            sum_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            for (int i = 0; i < NUM_OPERANDS; i++)
                slot[i] <= '0;
        end else begin
            pb_q   <= bus.pb;
            rot_q  <= bus.rot;
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ld_hit)
                        slot[ld_idx] <= bus.y;
                    if (rot_rise) begin
                        state  <= ACCUM;
                        idx    <= '0;
                        acc    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc <= acc + addend;
                    idx <= idx + IDXW'(1);
                    if (idx == LAST) begin
                        sum_r  <= acc + addend;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        idx    <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sum  = sum_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule
